pipeline_issue_ctrl: RTL

//  Issue scheduler in front of the Pipeline InstrIn port. Buffers incoming 32-bit instructions in a small FIFO.

---
 rtl/pipeline_issue_ctrl_if.sv | 18 +
 rtl/pipeline_issue_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/pipeline_issue_ctrl_if.sv
// Enqueue handshake between the instruction source and the issue scheduler.
interface pipeline_issue_ctrl_if;
  logic [31:0] instr_in;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    output instr_in,
    output instr_valid,
    input  instr_ready
  );

  modport slave (
    input  instr_in,
    input  instr_valid,
    output instr_ready
  );
endinterface

// File: rtl/pipeline_issue_ctrl.sv
// Issue scheduler: instruction FIFO plus RAW scoreboard; issues one word per cycle, NOP on hazard.
// Optional macro STALL_COUNT_EN adds a saturating stall-cycle counter on port stall_cnt.
module pipeline_issue_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PIPE_DEPTH = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  pipeline_issue_ctrl_if.slave          in_if,
  input  logic                          flush,
  output logic [31:0]                   issue_instr,
  output logic                          issue_valid,
  output logic                          stall,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
`ifdef STALL_COUNT_EN
  ,
  output logic [15:0]                   stall_cnt
`endif
);

  localparam int PtrW = $clog2(FIFO_DEPTH);
  localparam int CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StStall} state_e;

  state_e                state_q, state_d;
  logic [31:0]           mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wptr_q, rptr_q;
  logic [CntW-1:0]       count_q, count_d;
  logic [31:0]           issue_instr_q;
  logic [PIPE_DEPTH-1:0] sb_valid_q;
  logic [4:0]            sb_rd_q [PIPE_DEPTH];

  logic        full, empty, push, pop, hazard;
  logic [31:0] head;
  logic        head_itype;
  logic [4:0]  head_rd, head_rs, head_rt;

  assign full  = (count_q == CntW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign in_if.instr_ready = ~full;
  // A push coinciding with flush is discarded.
  assign push = in_if.instr_valid & ~full & ~flush;

  assign head       = mem_q[rptr_q];
  assign head_itype = head[29];
  assign head_rd    = head[25:21];
  assign head_rs    = head[20:16];
  assign head_rt    = head[15:11];

  // R0 never matches: valid scoreboard entries never hold rd 0.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < int'(PIPE_DEPTH); i++) begin
      if (sb_valid_q[i]) begin
        if (head_rs == sb_rd_q[i]) hazard = 1'b1;
        if (!head_itype && (head_rt == sb_rd_q[i])) hazard = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = StIdle;
    if (!flush && !empty) begin
      state_d = hazard ? StStall : StIssue;
    end
  end

  assign pop = (state_d == StIssue);

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StIdle;
      issue_instr_q <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
      sb_valid_q    <= '0;
    end else begin
      state_q       <= state_d;
      issue_instr_q <= pop ? head : '0;
      count_q       <= count_d;
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (flush) begin
        rptr_q <= wptr_q;
      end else if (pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      // Scoreboard ages every cycle, including through a flush.
      sb_valid_q[0] <= pop && (head_rd != '0);
      for (int i = 1; i < int'(PIPE_DEPTH); i++) begin
        sb_valid_q[i] <= sb_valid_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= in_if.instr_in;
    sb_rd_q[0] <= head_rd;
    for (int i = 1; i < int'(PIPE_DEPTH); i++) begin
      sb_rd_q[i] <= sb_rd_q[i-1];
    end
  end

  assign issue_instr = issue_instr_q;
  assign issue_valid = (state_q == StIssue);
  assign stall       = (state_q == StStall);
  assign fifo_count  = count_q;
  assign busy        = ~empty | (|sb_valid_q);

`ifdef STALL_COUNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if ((state_d == StStall) && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
